// File: rtl/bias_load_ctrl_pkg.sv
// Shared sizing, FSM encoding and count clamp for the bias buffer load path.
// Used by the bias array, the read-op module and this controller.
package bias_load_ctrl_pkg;

    localparam int FW          = 32;
    localparam int DW          = 512;
    localparam int RL          = 512;
    localparam int PACKAGE_LEN = DW / FW;
    localparam int PACKAGE_NUM = RL / PACKAGE_LEN;
    localparam int BEAT_SHIFT  = $clog2(DW / 8);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic logic [5:0] clamp_pkg_num(input logic [5:0] num);
        return (num > 6'(PACKAGE_NUM)) ? 6'(PACKAGE_NUM) : num;
    endfunction

endpackage

// File: rtl/bias_load_wr.sv
// Registered write stage: turns each accepted response beat into one
// bias array write one cycle later, with an incrementing package index.
module bias_load_wr
    import bias_load_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          accept,
    input  logic          valid,
    input  logic [DW-1:0] data,
    output logic [5:0]    wcnt,
    output logic          bias_en,
    output logic [4:0]    bias_addr,
    output logic [DW-1:0] bias_data
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt      <= '0;
            bias_en   <= 1'b0;
            bias_addr <= '0;
            bias_data <= '0;
        end else if (clr) begin
            wcnt    <= '0;
            bias_en <= 1'b0;
        end else begin
            bias_en <= accept && valid;
            if (accept && valid) begin
                bias_addr <= wcnt[4:0];
                bias_data <= data;
                wcnt      <= wcnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/bias_load_ctrl.sv
// Bias load controller: issues sequential package reads from memory and
// writes the returned packages into the bias register array.
module bias_load_ctrl
    import bias_load_ctrl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [5:0]    pkg_num_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_req_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic          rd_ack_i,
    input  logic          rd_valid_i,
    input  logic [DW-1:0] rd_data_i,
    output logic          bias_en_o,
    output logic [4:0]    bias_addr_o,
    output logic [DW-1:0] bias_data_o
);

    state_t        state;
    logic [5:0]    n;
    logic [5:0]    rcnt;
    logic [5:0]    wcnt;
    logic [5:0]    num_clamped;
    logic [AW-1:0] base;
    logic          clr;
    logic          accept;
    logic          req_hs;
    logic          last_wr;

    assign num_clamped = clamp_pkg_num(pkg_num_i);
    assign clr         = (state == ST_IDLE) && start_i;
    assign accept      = (state == ST_REQ) || (state == ST_WAIT);
    assign rd_req_o    = (state == ST_REQ);
    assign rd_addr_o   = rd_req_o ? base + (AW'(rcnt) << BEAT_SHIFT) : '0;
    assign busy_o      = accept;
    assign done_o      = (state == ST_DONE);
    assign req_hs      = rd_req_o && rd_ack_i;
    // wcnt has already advanced past the final package when its write is on the bus
    assign last_wr     = bias_en_o && (wcnt == n);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
            n     <= '0;
            rcnt  <= '0;
            base  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        base  <= base_addr_i;
                        n     <= num_clamped;
                        rcnt  <= '0;
                        state <= (num_clamped == '0) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_hs) begin
                        rcnt <= rcnt + 6'd1;
                        if (rcnt == n - 6'd1) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (last_wr) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    bias_load_wr u_wr (
        .clk       (clk_i),
        .rstn      (rstn_i),
        .clr       (clr),
        .accept    (accept),
        .valid     (rd_valid_i),
        .data      (rd_data_i),
        .wcnt      (wcnt),
        .bias_en   (bias_en_o),
        .bias_addr (bias_addr_o),
        .bias_data (bias_data_o)
    );

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Self-checking bench for bias_load_ctrl: memory responder, transaction-level
// reference model compared every cycle, plus directed scenario checks.
module tb_bias_load_ctrl;
    import bias_load_ctrl_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [5:0]    pkg_num = '0;
    logic          rd_ack = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          busy, done, rd_req, bias_en;
    logic [AW-1:0] rd_addr;
    logic [4:0]    bias_addr;
    logic [DW-1:0] bias_data;

    int tests = 0;
    int fails = 0;

    bias_load_ctrl #(.AW(AW)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .base_addr_i (base_addr),
        .pkg_num_i   (pkg_num),
        .busy_o      (busy),
        .done_o      (done),
        .rd_req_o    (rd_req),
        .rd_addr_o   (rd_addr),
        .rd_ack_i    (rd_ack),
        .rd_valid_i  (rd_valid),
        .rd_data_i   (rd_data),
        .bias_en_o   (bias_en),
        .bias_addr_o (bias_addr),
        .bias_data_o (bias_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic          m_active = 1'b0;
    logic          m_last = 1'b0;
    int            m_n = 0, m_iss = 0, m_wr = 0, m_clamp;
    logic [AW-1:0] m_base = '0;
    logic          exp_en = 1'b0, exp_done = 1'b0, exp_req;
    logic [4:0]    exp_baddr = '0;
    logic [DW-1:0] exp_bdata = '0;
    logic [AW-1:0] exp_addr;

    always_comb begin
        m_clamp  = (pkg_num > 6'd32) ? 32 : int'(pkg_num);
        exp_req  = m_active && (m_iss < m_n);
        exp_addr = exp_req ? m_base + AW'(m_iss * (DW / 8)) : '0;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active <= 1'b0; m_last <= 1'b0; m_n <= 0; m_iss <= 0; m_wr <= 0;
            m_base <= '0; exp_en <= 1'b0; exp_done <= 1'b0; exp_baddr <= '0; exp_bdata <= '0;
        end else begin
            exp_en   <= 1'b0;
            exp_done <= 1'b0;
            m_last   <= 1'b0;
            if (m_active) begin
                if (m_iss < m_n && rd_ack) m_iss <= m_iss + 1;
                if (rd_valid) begin
                    exp_en    <= 1'b1;
                    exp_baddr <= 5'(m_wr);
                    exp_bdata <= rd_data;
                    m_wr      <= m_wr + 1;
                    if (m_wr == m_n - 1) m_last <= 1'b1;
                end
                if (m_last) begin
                    m_active <= 1'b0;
                    exp_done <= 1'b1;
                end
            end else if (!exp_done && start) begin
                m_base <= base_addr;
                m_n    <= m_clamp;
                m_iss  <= 0;
                m_wr   <= 0;
                if (m_clamp == 0) exp_done <= 1'b1;
                else              m_active <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("rd_req", DW'(rd_req), DW'(exp_req));
        chk("rd_addr", DW'(rd_addr), DW'(exp_addr));
        chk("busy", DW'(busy), DW'(m_active));
        chk("done", DW'(done), DW'(exp_done));
        chk("bias_en", DW'(bias_en), DW'(exp_en));
        if (exp_en) begin
            chk("bias_addr", DW'(bias_addr), DW'(exp_baddr));
            chk("bias_data", bias_data, exp_bdata);
        end
    end

    // ---------------- memory responder ----------------
    typedef struct { logic [AW-1:0] addr; int ready; } resp_t;
    resp_t         rq[$];
    resp_t         head;
    int            cyc = 0, last_ready = 0, stall = 0, r_tmp;
    int            ack_mode = 0, lat_lo = 1, lat_hi = 1;
    logic          stray = 1'b0;
    logic [31:0]   seed = 32'h5EED_1234;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int unsigned j = 0; j < DW / 32; j++) d[j*32 +: 32] = a ^ (j * 32'h9E37_79B9) ^ seed;
        return d;
    endfunction

    initial forever begin
        @(negedge clk);
        if (rstn && rd_req && rd_ack) begin
            r_tmp = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (r_tmp <= last_ready) r_tmp = last_ready + 1;
            last_ready = r_tmp;
            rq.push_back('{rd_addr, r_tmp});
            stall = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        rd_valid = 1'b0;
        if (rq.size() > 0 && rq[0].ready <= cyc) begin
            head     = rq.pop_front();
            rd_valid = 1'b1;
            rd_data  = mem_fn(head.addr);
        end else if (stray) begin
            rd_valid = 1'b1;
            rd_data  = {(DW / 32){$urandom()}};
        end
        case (ack_mode)
            0: rd_ack = 1'b1;
            1: if (rd_req && stall < 3) begin rd_ack = 1'b0; stall++; end else rd_ack = 1'b1;
            default: rd_ack = 1'($urandom_range(1, 0));
        endcase
    end

    // ---------------- event monitor ----------------
    int            n_wr = 0, n_hs = 0, n_done = 0;
    logic [AW-1:0] hs_addr[4096];
    logic [4:0]    wr_baddr[4096];

    always @(negedge clk) begin
        if (rstn) begin
            if (bias_en) begin wr_baddr[n_wr % 4096] = bias_addr; n_wr++; end
            if (rd_req && rd_ack) begin hs_addr[n_hs % 4096] = rd_addr; n_hs++; end
            if (done) n_done++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_load(input logic [AW-1:0] b, input logic [5:0] p, input int mid_k, output int lat);
        lat = -1;
        @(posedge clk);
        #1;
        base_addr = b; pkg_num = p; start = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (mid_k != 0 && k == mid_k) begin start = 1'b1; base_addr = $urandom(); pkg_num = 6'd5; end
            if (mid_k != 0 && k == mid_k + 1) start = 1'b0;
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
        if (lat < 0) begin
            tests++; fails++;
            $display("FAIL load timeout: got no done_o, expected done_o within 600 cycles");
        end
    endtask

    task automatic load_and_check(input string nm, input logic [AW-1:0] b, input logic [5:0] p,
                                  input int mid_k, output int lat);
        int s_wr = n_wr;
        int s_hs = n_hs;
        int s_dn = n_done;
        int en   = (p > 6'd32) ? 32 : int'(p);
        run_load(b, p, mid_k, lat);
        for (int i = 0; i < 200 && rq.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({nm, " writes"}, DW'(n_wr - s_wr), DW'(en));
        chk({nm, " requests"}, DW'(n_hs - s_hs), DW'(en));
        chk({nm, " done pulses"}, DW'(n_done - s_dn), DW'(1));
        if (en > 0) begin
            chk({nm, " first wr addr"}, DW'(wr_baddr[s_wr % 4096]), DW'(0));
            chk({nm, " last wr addr"}, DW'(wr_baddr[(n_wr - 1) % 4096]), DW'(en - 1));
            chk({nm, " first rd addr"}, DW'(hs_addr[s_hs % 4096]), DW'(b));
            chk({nm, " last rd addr"}, DW'(hs_addr[(n_hs - 1) % 4096]), DW'(b + AW'((en - 1) * 64)));
        end
    endtask

    initial begin
        int lat, s_wr, s_hs;
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset rd_req", DW'(rd_req), '0);
        chk("reset busy", DW'(busy), '0);
        chk("reset done", DW'(done), '0);
        chk("reset bias_en", DW'(bias_en), '0);
        chk("reset rd_addr", DW'(rd_addr), '0);
        chk("reset bias_addr", DW'(bias_addr), '0);
        chk("reset bias_data", bias_data, '0);
        @(posedge clk);
        #1 rstn = 1'b1;

        ack_mode = 0; lat_lo = 2; lat_hi = 2;
        s_hs = n_hs;
        load_and_check("full", 32'h1000_0000, 6'd32, 0, lat);
        chk("full first req", DW'(hs_addr[s_hs % 4096]), DW'(32'h1000_0000));
        chk("full last req", DW'(hs_addr[(s_hs + 31) % 4096]), DW'(32'h1000_07C0));

        ack_mode = 1; lat_lo = 1; lat_hi = 3;
        load_and_check("backpressure", 32'h2000_0040, 6'd4, 0, lat);

        ack_mode = 0; lat_lo = 1; lat_hi = 1;
        load_and_check("zero", 32'h3000_0000, 6'd0, 0, lat);
        load_and_check("clamp", 32'h0000_0100, 6'd40, 0, lat);

        load_and_check("best case", 32'h4000_0000, 6'd4, 0, lat);
        chk("best case latency", DW'(lat), DW'(7));

        ack_mode = 2; lat_lo = 1; lat_hi = 4;
        load_and_check("overlap mid start", $urandom(), 6'd8, 3, lat);

        s_wr = n_wr;
        @(posedge clk);
        #1 stray = 1'b1;
        repeat (5) @(posedge clk);
        #1 stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray idle writes", DW'(n_wr - s_wr), '0);

        ack_mode = 0; lat_lo = 6; lat_hi = 6;
        s_wr = n_wr;
        @(posedge clk);
        #1 base_addr = 32'h5000_0000; pkg_num = 6'd16; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 300 && (n_wr - s_wr) < 5; i++) @(negedge clk);
        chk("pre-reset writes", DW'(n_wr - s_wr >= 5), DW'(1));
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("midreset rd_req", DW'(rd_req), '0);
        chk("midreset busy", DW'(busy), '0);
        chk("midreset bias_en", DW'(bias_en), '0);
        chk("midreset rd_addr", DW'(rd_addr), '0);
        chk("midreset bias_addr", DW'(bias_addr), '0);
        chk("midreset bias_data", bias_data, '0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        s_wr = n_wr;
        for (int i = 0; i < 200 && rq.size() > 0; i++) @(posedge clk);
        repeat (4) @(negedge clk);
        chk("post-reset stale writes", DW'(n_wr - s_wr), '0);
        lat_lo = 1; lat_hi = 2;
        load_and_check("after reset", 32'h6000_0000, 6'd4, 0, lat);

        for (int t = 0; t < 6; t++) begin
            ack_mode = int'($urandom_range(2, 0));
            lat_lo   = int'($urandom_range(3, 1));
            lat_hi   = lat_lo + int'($urandom_range(2, 0));
            seed     = $urandom();
            load_and_check("random", $urandom(), 6'($urandom_range(63, 0)), 0, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected end of run");
        $fatal(1);
    end

endmodule
